// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer:
// state enum, opcodes, datapath select codes and the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       instr_retired;
  } ctrl_t;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] s;
    s = IMM_I;
    unique case (1'b1)
      (op == OP_SW):  s = IMM_S;
      (op == OP_BEQ): s = IMM_B;
      (op == OP_JAL): s = IMM_J;
      default:        s = IMM_I;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified instruction/data memory port handshake
// between the sequencer and the memory.
interface multicycle_controller_if;
  logic mem_req;
  logic adr_src;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output adr_src,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  adr_src,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore control word per state; only FETCH/MEMWRITE
// look at mem_ready and BEQ looks at zero.
module mc_output_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic pc_update;
  logic branch;

  always_comb begin
    ctrl = '0;
    pc_update = 1'b0;
    branch = 1'b0;
    ctrl.imm_src = imm_sel(op);
    unique case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b0;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          pc_update = 1'b1;
          ctrl.alu_src_a = SRCA_PC;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op = ALU_ADD;
          ctrl.result_src = RES_ALU;
        end
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op = ALU_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op = ALU_ADD;
      end
      MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.instr_retired = mem_ready;
      end
      EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op = ALU_FUNCT;
      end
      EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        branch = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op = ALU_ADD;
        ctrl.result_src = RES_ALUOUT;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    ctrl.pc_write = pc_update | (branch & zero);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: state register,
// next-state logic and the sticky illegal-opcode flag.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        bus,
  input  logic [6:0]                     op,
  input  logic                           zero,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           reg_write,
  output logic [1:0]                     result_src,
  output logic [1:0]                     alu_src_a,
  output logic [1:0]                     alu_src_b,
  output logic [1:0]                     alu_op,
  output logic [1:0]                     imm_src,
  output logic                           instr_retired,
  output logic                           illegal_instr
);

  state_t state;
  state_t nxt;
  logic   illegal_q;
  ctrl_t  ctrl;
  ctrl_t  gated;

  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:    if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  nxt = MEMADR;
          (op == OP_R):   nxt = EXECUTER;
          (op == OP_I):   nxt = EXECUTEI;
          (op == OP_BEQ): nxt = BEQ;
          (op == OP_JAL): nxt = JAL;
          default:        nxt = ILLEGAL;
        endcase
      end
      MEMADR:   nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.mem_ready) nxt = MEMWB;
      MEMWB:    nxt = FETCH;
      MEMWRITE: if (bus.mem_ready) nxt = FETCH;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
      JAL:      nxt = ALUWB;
      ILLEGAL:  nxt = ILLEGAL;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == ILLEGAL) illegal_q <= 1'b1;
    end
  end

  mc_output_decode u_dec (
    .state     (state),
    .op        (op),
    .zero      (zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Reset masks every strobe and select, abandoning any access.
  assign gated = rst_n ? ctrl : '0;

  assign bus.mem_req    = gated.mem_req;
  assign bus.adr_src    = gated.adr_src;
  assign bus.mem_write  = gated.mem_write;
  assign ir_write       = gated.ir_write;
  assign pc_write       = gated.pc_write;
  assign reg_write      = gated.reg_write;
  assign result_src     = gated.result_src;
  assign alu_src_a      = gated.alu_src_a;
  assign alu_src_b      = gated.alu_src_b;
  assign alu_op         = gated.alu_op;
  assign imm_src        = gated.imm_src;
  assign instr_retired  = gated.instr_retired;
  assign illegal_instr  = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for the multi-cycle sequencer:
// per-cycle control words checked against hand-built vectors.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic       zero = 1'b0;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [1:0] alu_op, imm_src;
  logic       instr_retired, illegal_instr;
  int         n_cmp = 0;
  int         n_fail = 0;

  multicycle_controller_if mif();

  multicycle_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (mif.master),
    .op            (op),
    .zero          (zero),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .imm_src       (imm_src),
    .instr_retired (instr_retired),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // {mem_req,adr_src,mem_write,ir_write,pc_write,reg_write,
  //  result_src,alu_src_a,alu_src_b,alu_op,instr_retired}
  logic [14:0] obs;
  assign obs = {mif.mem_req, mif.adr_src, mif.mem_write,
                ir_write, pc_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, instr_retired};

  localparam logic [14:0] ZW    = 15'b0;
  localparam logic [14:0] F_RDY = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] F_STL = {6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] DEC   = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] MADR  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] MRD   = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] MWB   = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [14:0] MWR_W = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] MWR_D = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [14:0] EXR   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] EXI   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
  localparam logic [14:0] AWB   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [14:0] BEQ1  = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1};
  localparam logic [14:0] BEQ0  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1};
  localparam logic [14:0] JALS  = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op = 7'b1101111;
    mif.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({obs, imm_src, illegal_instr} !== {ZW, 2'b00, 1'b0}) begin
        n_fail++;
        $display("FAIL reset c%0d got=%h/%b/%b want=%h/00/0",
                 i, obs, imm_src, illegal_instr, ZW);
      end
      tick();
    end
    rst_n = 1'b1;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== F_STL) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=%h", obs, F_STL);
    end
    tick();
  endtask

  task automatic test_lw();
    logic [14:0] ev [5];
    ev = '{F_RDY, DEC, MADR, MRD, MWB};
    op = 7'b0000011;
    mif.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL lw c%0d got=%h want=%h", i, obs, ev[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (imm_src !== 2'b00) begin
          n_fail++;
          $display("FAIL lw_imm got=%b want=00", imm_src);
        end
      end
      tick();
    end
  endtask

  task automatic test_lw_stalls();
    logic [14:0] ev [7];
    logic        rdy [7];
    ev  = '{F_STL, F_RDY, DEC, MADR, MRD, MRD, MWB};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 7'b0000011;
    for (int i = 0; i < 7; i++) begin
      mif.mem_ready = rdy[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL lw_stall c%0d got=%h want=%h", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw_stall();
    logic [14:0] ev [6];
    logic        rdy [6];
    int          nw, nr;
    ev  = '{F_RDY, DEC, MADR, MWR_W, MWR_W, MWR_D};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    nw = 0;
    nr = 0;
    op = 7'b0100011;
    for (int i = 0; i < 6; i++) begin
      mif.mem_ready = rdy[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL sw c%0d got=%h want=%h", i, obs, ev[i]);
      end
      if (mif.mem_write === 1'b1) nw++;
      if (instr_retired === 1'b1) nr++;
      if (i == 1) begin
        n_cmp++;
        if (imm_src !== 2'b01) begin
          n_fail++;
          $display("FAIL sw_imm got=%b want=01", imm_src);
        end
      end
      tick();
    end
    n_cmp++;
    if (nw !== 3 || nr !== 1) begin
      n_fail++;
      $display("FAIL sw_counts got=%0d/%0d want=3/1", nw, nr);
    end
  endtask

  task automatic test_alu();
    logic [14:0] er [4];
    logic [14:0] ei [4];
    er = '{F_RDY, DEC, EXR, AWB};
    ei = '{F_RDY, DEC, EXI, AWB};
    mif.mem_ready = 1'b1;
    op = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== er[i]) begin
        n_fail++;
        $display("FAIL rtype c%0d got=%h want=%h", i, obs, er[i]);
      end
      tick();
    end
    op = 7'b0010011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== ei[i]) begin
        n_fail++;
        $display("FAIL itype c%0d got=%h want=%h", i, obs, ei[i]);
      end
      tick();
    end
  endtask

  task automatic test_beq();
    logic [14:0] e1 [3];
    logic [14:0] e0 [3];
    e1 = '{F_RDY, DEC, BEQ1};
    e0 = '{F_RDY, DEC, BEQ0};
    mif.mem_ready = 1'b1;
    op = 7'b1100011;
    zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== e1[i]) begin
        n_fail++;
        $display("FAIL beq_taken c%0d got=%h want=%h", i, obs, e1[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (imm_src !== 2'b10) begin
          n_fail++;
          $display("FAIL beq_imm got=%b want=10", imm_src);
        end
      end
      tick();
    end
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== e0[i]) begin
        n_fail++;
        $display("FAIL beq_not c%0d got=%h want=%h", i, obs, e0[i]);
      end
      tick();
    end
  endtask

  task automatic test_jal();
    logic [14:0] ev [4];
    ev = '{F_RDY, DEC, JALS, AWB};
    mif.mem_ready = 1'b1;
    op = 7'b1101111;
    zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL jal c%0d got=%h want=%h", i, obs, ev[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (imm_src !== 2'b11) begin
          n_fail++;
          $display("FAIL jal_imm got=%b want=11", imm_src);
        end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    mif.mem_ready = 1'b1;
    op = 7'b0110111;
    @(negedge clk);
    n_cmp++;
    if (obs !== F_RDY) begin
      n_fail++;
      $display("FAIL ill_fetch got=%h want=%h", obs, F_RDY);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({obs, illegal_instr} !== {DEC, 1'b0}) begin
      n_fail++;
      $display("FAIL ill_decode got=%h/%b want=%h/0", obs, illegal_instr, DEC);
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      mif.mem_ready = i[0];
      @(negedge clk);
      n_cmp++;
      if ({obs, imm_src, illegal_instr} !== {ZW, 2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL ill_hold c%0d got=%h/%b want=%h/1",
                 i, obs, illegal_instr, ZW);
      end
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== ZW) begin
      n_fail++;
      $display("FAIL ill_rst_out got=%h want=%h", obs, ZW);
    end
    tick();
    n_cmp++;
    if (illegal_instr !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_clear got=%b want=0", illegal_instr);
    end
    rst_n = 1'b1;
    mif.mem_ready = 1'b0;
    op = 7'b0000011;
    @(negedge clk);
    n_cmp++;
    if ({obs, illegal_instr} !== {F_STL, 1'b0}) begin
      n_fail++;
      $display("FAIL ill_refetch got=%h/%b want=%h/0", obs, illegal_instr, F_STL);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [14:0] ev [4];
    ev = '{F_RDY, DEC, MADR, MWR_W};
    op = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      mif.mem_ready = (i == 0);
      @(negedge clk);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL rst_mid c%0d got=%h want=%h", i, obs, ev[i]);
      end
      tick();
    end
    rst_n = 1'b0;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== ZW) begin
      n_fail++;
      $display("FAIL rst_mid_abandon got=%h want=%h", obs, ZW);
    end
    tick();
    rst_n = 1'b1;
    mif.mem_ready = 1'b1;
    op = 7'b0000011;
    @(negedge clk);
    n_cmp++;
    if (obs !== F_RDY) begin
      n_fail++;
      $display("FAIL rst_mid_fetch got=%h want=%h", obs, F_RDY);
    end
    tick();
    mif.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== DEC) begin
      n_fail++;
      $display("FAIL rst_mid_decode got=%h want=%h", obs, DEC);
    end
    tick();
    @(negedge clk);
    tick();
    mif.mem_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_lw_stalls();
    test_sw_stall();
    test_alu();
    test_beq();
    test_jal();
    test_reset_mid_access();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
